window_var_scan: RTL and testbench

Downstream consumer of the integral-image stage. Once both the integral image and the squared integral image of a frame are stable, this block sweeps a fixed-size detection window across every legal position in raster order. For each position it computes the window pixel sum, the sum of squares and the scaled variance, and streams one result per window through a valid/ready handshake to the cascade classifier.

---
 rtl/window_var_scan.sv | 142 ++++++++++++++
 tb/tb_window_var_scan.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/window_var_scan.sv
// window_var_scan: sweeps a fixed-size window over an integral image pair and
// streams each window's sum, sum of squares and scaled variance.
//   clock, reset       : system clock, asynchronous active-high reset
//   start_i            : one-cycle scan request, honoured only when idle
//   int_img_i          : inclusive integral image, 18-bit entries
//   int_img_sq_i       : inclusive squared integral image, 32-bit entries
//   win_valid_o/ready_i: result handshake; outputs hold while stalled
//   win_x_o, win_y_o   : window top-left coordinate
//   win_sum_o          : pixel sum in window
//   win_sq_sum_o       : sum of squared pixels in window
//   win_var_o          : N*sq_sum - sum^2, N = WIN_SIZE^2
//   busy_o             : scan in progress
//   scan_done_o        : one-cycle pulse after the last transfer
`ifndef LAPTOP_WIDTH
`define LAPTOP_WIDTH 40
`endif
`ifndef LAPTOP_HEIGHT
`define LAPTOP_HEIGHT 30
`endif
module window_var_scan #(
    parameter int WIDTH_LIMIT  = `LAPTOP_WIDTH,
    parameter int HEIGHT_LIMIT = `LAPTOP_HEIGHT,
    parameter int WIN_SIZE     = 24,
    parameter int STEP         = 1
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic                                          start_i,
    input  logic [HEIGHT_LIMIT-1:0][WIDTH_LIMIT-1:0][17:0] int_img_i,
    input  logic [HEIGHT_LIMIT-1:0][WIDTH_LIMIT-1:0][31:0] int_img_sq_i,
    output logic                                          win_valid_o,
    input  logic                                          win_ready_i,
    output logic [15:0]                                   win_x_o,
    output logic [15:0]                                   win_y_o,
    output logic [17:0]                                   win_sum_o,
    output logic [31:0]                                   win_sq_sum_o,
    output logic [35:0]                                   win_var_o,
    output logic                                          busy_o,
    output logic                                          scan_done_o
);
    localparam int NX = (WIDTH_LIMIT - WIN_SIZE) / STEP + 1;
    localparam int NY = (HEIGHT_LIMIT - WIN_SIZE) / STEP + 1;
    localparam int XW = (WIDTH_LIMIT > 1) ? $clog2(WIDTH_LIMIT) : 1;
    localparam int YW = (HEIGHT_LIMIT > 1) ? $clog2(HEIGHT_LIMIT) : 1;
    localparam logic [35:0] N = 36'(WIN_SIZE * WIN_SIZE);
    localparam logic [XW-1:0] X_LAST = XW'((NX - 1) * STEP);
    localparam logic [YW-1:0] Y_LAST = YW'((NY - 1) * STEP);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;
    state_t state_q;

    logic [XW-1:0] x_q, x_d, xm1, xe, x1_q, x2_q, x3_q;
    logic [YW-1:0] y_q, y_d, ym1, ye, y1_q, y2_q, y3_q;
    logic stall, last_pos, drained;
    logic v1_q, v2_q, v3_q;
    logic [17:0] a_d, b_d, c_d, d_d, a_q, b_q, c_q, d_q, sum2_q, sum3_q;
    logic [31:0] sa_d, sb_d, sc_d, sd_d, sa_q, sb_q, sc_q, sd_q, sq2_q, sq3_q;
    logic [35:0] pn_q, ps_q;

    assign busy_o = state_q != IDLE;

    always_comb begin
        stall    = win_valid_o && !win_ready_i;
        last_pos = x_q == X_LAST && y_q == Y_LAST;
        // last result leaves the output register with nothing behind it
        drained  = win_valid_o && win_ready_i && !v1_q && !v2_q && !v3_q;
        x_d      = (x_q == X_LAST) ? '0 : x_q + XW'(STEP);
        y_d      = (x_q == X_LAST) ? y_q + YW'(STEP) : y_q;
        xm1      = x_q - XW'(1);
        ym1      = y_q - YW'(1);
        xe       = x_q + XW'(WIN_SIZE - 1);
        ye       = y_q + YW'(WIN_SIZE - 1);
        // corners above or left of the frame read as zero
        a_d  = (x_q == '0 || y_q == '0) ? '0 : int_img_i[ym1][xm1];
        b_d  = (y_q == '0) ? '0 : int_img_i[ym1][xe];
        c_d  = (x_q == '0) ? '0 : int_img_i[ye][xm1];
        d_d  = int_img_i[ye][xe];
        sa_d = (x_q == '0 || y_q == '0) ? '0 : int_img_sq_i[ym1][xm1];
        sb_d = (y_q == '0) ? '0 : int_img_sq_i[ym1][xe];
        sc_d = (x_q == '0) ? '0 : int_img_sq_i[ye][xm1];
        sd_d = int_img_sq_i[ye][xe];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            scan_done_o <= 1'b0;
        end else begin
            scan_done_o <= 1'b0;
            case (state_q)
                IDLE: if (start_i) begin
                    state_q <= SCAN;
                    x_q     <= '0;
                    y_q     <= '0;
                end
                SCAN: if (!stall) begin
                    x_q <= last_pos ? '0 : x_d;
                    y_q <= last_pos ? '0 : y_d;
                    if (last_pos) state_q <= DRAIN;
                end
                DRAIN: if (drained) begin
                    state_q     <= IDLE;
                    scan_done_o <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // whole pipeline freezes while the output is offered but not taken
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            {v1_q, v2_q, v3_q, win_valid_o} <= '0;
            {a_q, b_q, c_q, d_q, sa_q, sb_q, sc_q, sd_q} <= '0;
            {x1_q, y1_q, x2_q, y2_q, x3_q, y3_q} <= '0;
            {sum2_q, sq2_q, sum3_q, sq3_q, pn_q, ps_q} <= '0;
            {win_x_o, win_y_o, win_sum_o, win_sq_sum_o, win_var_o} <= '0;
        end else if (!stall) begin
            v1_q <= state_q == SCAN;
            {a_q, b_q, c_q, d_q} <= {a_d, b_d, c_d, d_d};
            {sa_q, sb_q, sc_q, sd_q} <= {sa_d, sb_d, sc_d, sd_d};
            {x1_q, y1_q} <= {x_q, y_q};
            v2_q   <= v1_q;
            sum2_q <= d_q - b_q - c_q + a_q;
            sq2_q  <= sd_q - sb_q - sc_q + sa_q;
            {x2_q, y2_q} <= {x1_q, y1_q};
            v3_q   <= v2_q;
            pn_q   <= N * 36'(sq2_q);
            ps_q   <= 36'(sum2_q) * 36'(sum2_q);
            {sum3_q, sq3_q} <= {sum2_q, sq2_q};
            {x3_q, y3_q} <= {x2_q, y2_q};
            win_valid_o  <= v3_q;
            win_var_o    <= pn_q - ps_q;
            win_sum_o    <= sum3_q;
            win_sq_sum_o <= sq3_q;
            win_x_o      <= 16'(x3_q);
            win_y_o      <= 16'(y3_q);
        end
    end
endmodule

// File: tb/tb_window_var_scan.sv
// tb_window_var_scan: scoreboard bench for window_var_scan on three frame sizes.
module tb_window_var_scan;
    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [17:0] s;
        logic [31:0] q;
        logic [35:0] v;
    } win_t;

    localparam int W0 = 40, H0 = 30;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic st[3], rdy[3], vld[3], bsy[3], dn[3];
    logic [15:0] wx[3], wy[3];
    logic [17:0] ws[3];
    logic [31:0] wq[3];
    logic [35:0] wv[3];

    logic [H0-1:0][W0-1:0][17:0] img0;
    logic [H0-1:0][W0-1:0][31:0] sq0;
    logic [24:0][25:0][17:0] img1;
    logic [24:0][25:0][31:0] sq1;
    logic [3:0][3:0][17:0] img2;
    logic [3:0][3:0][31:0] sq2;

    longint pix[H0][W0];
    longint ii[H0][W0];
    longint iq[H0][W0];
    win_t sb[3][$];
    int errs = 0, checks = 0;
    int dn_cnt[3], xf_cnt[3];

    window_var_scan #(.WIDTH_LIMIT(W0), .HEIGHT_LIMIT(H0)) d0 (
        .clock(clk), .reset(rst), .start_i(st[0]), .int_img_i(img0), .int_img_sq_i(sq0),
        .win_valid_o(vld[0]), .win_ready_i(rdy[0]), .win_x_o(wx[0]), .win_y_o(wy[0]),
        .win_sum_o(ws[0]), .win_sq_sum_o(wq[0]), .win_var_o(wv[0]), .busy_o(bsy[0]),
        .scan_done_o(dn[0]));
    window_var_scan #(.WIDTH_LIMIT(26), .HEIGHT_LIMIT(25)) d1 (
        .clock(clk), .reset(rst), .start_i(st[1]), .int_img_i(img1), .int_img_sq_i(sq1),
        .win_valid_o(vld[1]), .win_ready_i(rdy[1]), .win_x_o(wx[1]), .win_y_o(wy[1]),
        .win_sum_o(ws[1]), .win_sq_sum_o(wq[1]), .win_var_o(wv[1]), .busy_o(bsy[1]),
        .scan_done_o(dn[1]));
    window_var_scan #(.WIDTH_LIMIT(4), .HEIGHT_LIMIT(4), .WIN_SIZE(4)) d2 (
        .clock(clk), .reset(rst), .start_i(st[2]), .int_img_i(img2), .int_img_sq_i(sq2),
        .win_valid_o(vld[2]), .win_ready_i(rdy[2]), .win_x_o(wx[2]), .win_y_o(wy[2]),
        .win_sum_o(ws[2]), .win_sq_sum_o(wq[2]), .win_var_o(wv[2]), .busy_o(bsy[2]),
        .scan_done_o(dn[2]));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // every valid cycle is compared to the queue head, so a stalled output must
    // keep matching it; the head is retired only when the transfer happens
    task automatic mon(input int id);
        win_t o;
        if (dn[id] === 1'b1) dn_cnt[id]++;
        if (vld[id] === 1'b1) begin
            o = {wx[id], wy[id], ws[id], wq[id], wv[id]};
            if (sb[id].size() == 0) begin
                checks++;
                assert (sb[id].size() != 0) else begin
                    errs++;
                    $error("FAIL d%0d_extra observed window x=%0d y=%0d expected none", id, o.x, o.y);
                end
            end else begin
                chk($sformatf("d%0d_win", id), 128'(o), 128'(sb[id][0]));
                if (rdy[id] === 1'b1) begin
                    sb[id].delete(0);
                    xf_cnt[id]++;
                end
            end
        end
    endtask

    always @(negedge clk) for (int i = 0; i < 3; i++) mon(i);

    task automatic fill(input int mode);
        for (int y = 0; y < H0; y++)
            for (int x = 0; x < W0; x++)
                pix[y][x] = mode == 0 ? 64'd10 : mode == 1 ? (((x + y) & 1) != 0 ? 64'd255 : 64'd0) :
                            mode == 2 ? 64'd255 : longint'($urandom_range(255));
        for (int y = 0; y < H0; y++)
            for (int x = 0; x < W0; x++) begin
                ii[y][x] = pix[y][x] + (y > 0 ? ii[y-1][x] : 0) + (x > 0 ? ii[y][x-1] : 0)
                         - (x > 0 && y > 0 ? ii[y-1][x-1] : 0);
                iq[y][x] = pix[y][x] * pix[y][x] + (y > 0 ? iq[y-1][x] : 0) + (x > 0 ? iq[y][x-1] : 0)
                         - (x > 0 && y > 0 ? iq[y-1][x-1] : 0);
                img0[y][x] = 18'(ii[y][x]);
                sq0[y][x]  = 32'(iq[y][x]);
                if (y < 25 && x < 26) begin
                    img1[y][x] = 18'(ii[y][x]);
                    sq1[y][x]  = 32'(iq[y][x]);
                end
                if (y < 4 && x < 4) begin
                    img2[y][x] = 18'(ii[y][x]);
                    sq2[y][x]  = 32'(iq[y][x]);
                end
            end
    endtask

    // direct per-pixel model of each window, independent of the integral images
    task automatic push(input int id, input int wl, input int hl, input int n);
        longint s, q;
        win_t e;
        for (int y = 0; y + n <= hl; y++)
            for (int x = 0; x + n <= wl; x++) begin
                s = 0;
                q = 0;
                for (int j = 0; j < n; j++)
                    for (int i = 0; i < n; i++) begin
                        s += pix[y+j][x+i];
                        q += pix[y+j][x+i] * pix[y+j][x+i];
                    end
                e.x = 16'(x);
                e.y = 16'(y);
                e.s = 18'(s);
                e.q = 32'(q);
                e.v = 36'(longint'(n * n) * q - s * s);
                sb[id].push_back(e);
            end
    endtask

    task automatic go(input int id);
        st[id] = 1'b1;
        @(posedge clk);
        #1;
        st[id] = 1'b0;
    endtask

    task automatic run(input int id, input bit bp);
        int target;
        target = dn_cnt[id] + 1;
        for (int n = 0; n < 5000 && dn_cnt[id] < target; n++) begin
            @(posedge clk);
            #1;
            rdy[id] = bp ? ($urandom_range(9) < 3) : 1'b1;
            st[id]  = bp && bsy[id] === 1'b1 && $urandom_range(15) == 0;
        end
        st[id]  = 1'b0;
        rdy[id] = 1'b1;
        chk($sformatf("d%0d_done", id), 128'(dn_cnt[id]), 128'(target));
        repeat (3) @(posedge clk);
        #1;
        chk($sformatf("d%0d_done_once", id), 128'(dn_cnt[id]), 128'(target));
        chk($sformatf("d%0d_all_out", id), 128'(sb[id].size()), 128'(0));
        chk($sformatf("d%0d_idle", id), 128'(bsy[id]), 128'(0));
    endtask

    initial begin
        int base;
        for (int i = 0; i < 3; i++) begin
            st[i]  = 1'b0;
            rdy[i] = 1'b1;
        end
        fill(0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++)
            chk($sformatf("rst_d%0d", i),
                128'({vld[i], bsy[i], dn[i], wx[i], wy[i], ws[i], wq[i], wv[i]}), 128'(0));

        push(0, W0, H0, 24); go(0); run(0, 0);
        fill(1); push(0, W0, H0, 24); go(0); run(0, 0);
        fill(2); push(0, W0, H0, 24); go(0); run(0, 0);

        fill(3);
        push(1, 26, 25, 24);
        go(1);
        chk("d1_busy", 128'(bsy[1]), 128'(1));
        repeat (3) @(posedge clk);
        #1;
        chk("d1_lat_t3", 128'(vld[1]), 128'(0));
        @(posedge clk);
        #1;
        chk("d1_lat_t4", 128'(vld[1]), 128'(1));
        run(1, 0);
        push(1, 26, 25, 24); go(1); run(1, 1);
        push(0, W0, H0, 24); go(0); run(0, 1);

        push(0, W0, H0, 24);
        go(0);
        base = xf_cnt[0];
        for (int n = 0; n < 1000 && xf_cnt[0] < base + 5; n++) begin
            @(posedge clk);
            #1;
        end
        chk("d0_reach5", 128'(xf_cnt[0]), 128'(base + 5));
        base = dn_cnt[0];
        rst = 1'b1;
        sb[0].delete();
        #1;
        chk("d0_async_rst",
            128'({vld[0], bsy[0], dn[0], wx[0], wy[0], ws[0], wq[0], wv[0]}), 128'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("d0_no_done_rst", 128'(dn_cnt[0]), 128'(base));
        chk("d0_idle_rst", 128'(bsy[0]), 128'(0));
        push(0, W0, H0, 24); go(0); run(0, 0);

        push(2, 4, 4, 4);
        go(2);
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (dn[2] === 1'b1) break;
        end
        push(2, 4, 4, 4);
        st[2] = 1'b1;
        @(posedge clk);
        #1;
        st[2] = 1'b0;
        chk("d2_first_done", 128'(dn_cnt[2]), 128'(1));
        chk("d2_start_on_done", 128'(bsy[2]), 128'(1));
        run(2, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
